// File: rtl/neuromorphic_x1_row_seq.sv
// neuromorphic_x1_row_seq
// Row sequencer for a 32x32 X1 neuromorphic core. A row request is turned
// into 32 per-column commands on the EN/W_RB/DI strobe interface. Row reads
// then poll the core for 32 result bits, retrying while the core reports
// "empty". Every strobe is held until core_ack is seen and is followed by
// exactly one idle cycle.
// Optional build macro: X1_ROWSEQ_VERIFY_EN. When it is defined, a row write
// is followed by a read-back of the same row. The response then carries the
// read-back data and flags any difference from the written data.
module neuromorphic_x1_row_seq #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int POLL_LIMIT  = 4096
) (
    input  logic        CLKin,
    input  logic        RSTin,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [4:0]  req_row,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        EN,
    output logic        W_RB,
    output logic [31:0] DI,
    input  logic [31:0] DO,
    input  logic        core_ack,
    output logic        busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_ISSUE_GAP = 3'd2;
    localparam logic [2:0] S_POLL      = 3'd3;
    localparam logic [2:0] S_POLL_GAP  = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    localparam logic [31:0] EMPTY_WORD = 32'hDEAD_C0DE;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int EW = $clog2(POLL_LIMIT + 1);

    logic [2:0]    r_state;
    logic          r_outOfReset;
    logic          r_op;
    logic          r_readPhase;
    logic [4:0]    r_row;
    logic [31:0]   r_wdata;
    logic [5:0]    r_col;
    logic [5:0]    r_bit;
    logic [TW-1:0] r_timer;
    logic [EW-1:0] r_empty;
    logic          r_err;
    logic          r_en;
    logic          r_wrb;
    logic [31:0]   r_di;
    logic          r_rspValid;
    logic [31:0]   r_rspData;

    logic          w_colBit;
    logic          w_ackTimeout;
    logic          w_emptyHit;
    logic          w_lastEmpty;
    logic          w_badUpper;
    logic [31:0]   w_collectData;

    // A PROGRAM word carries FF/00 for the bit value; a READ word always carries 00.
    function automatic logic [31:0] cmdWord(input logic prog, input logic [4:0] row,
                                            input logic [4:0] col, input logic bitVal);
        cmdWord = {(prog ? 2'b11 : 2'b01), row, col, 12'h000,
                   ((prog && bitVal) ? 8'hFF : 8'h00)};
    endfunction

    assign w_colBit      = r_wdata[r_col[4:0]];
    assign w_ackTimeout  = (r_timer == TW'(ACK_TIMEOUT - 1));
    assign w_emptyHit    = (DO == EMPTY_WORD);
    assign w_lastEmpty   = (r_empty == EW'(POLL_LIMIT - 1));
    assign w_badUpper    = (DO[31:1] != 31'd0);
    assign w_collectData = r_rspData | (32'(DO[0]) << r_bit[4:0]);

    assign req_ready = (r_state == S_IDLE) && r_outOfReset;
    assign busy      = (r_state != S_IDLE);
    assign EN        = r_en;
    assign W_RB      = r_wrb;
    assign DI        = r_di;
    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    assign rsp_err   = r_err;

    // Keep req_ready low while in reset; it rises on the first clock after release.
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            r_outOfReset <= 1'b0;
        end else begin
            r_outOfReset <= 1'b1;
        end
    end

    // Main sequencer: command issue with ack handshake, result polling and response.
    always_ff @(posedge CLKin or posedge RSTin) begin
        if (RSTin) begin
            r_state     <= S_IDLE;
            r_op        <= 1'b0;
            r_readPhase <= 1'b0;
            r_row       <= 5'd0;
            r_wdata     <= 32'd0;
            r_col       <= 6'd0;
            r_bit       <= 6'd0;
            r_timer     <= '0;
            r_empty     <= '0;
            r_err       <= 1'b0;
            r_en        <= 1'b0;
            r_wrb       <= 1'b0;
            r_di        <= 32'd0;
            r_rspValid  <= 1'b0;
            r_rspData   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_op        <= req_op;
                        r_row       <= req_row;
                        r_wdata     <= req_data;
                        r_readPhase <= ~req_op;
                        r_col       <= 6'd0;
                        r_bit       <= 6'd0;
                        r_timer     <= '0;
                        r_empty     <= '0;
                        r_err       <= 1'b0;
                        r_rspData   <= 32'd0;
                        r_en        <= 1'b1;
                        r_wrb       <= 1'b1;
                        r_di        <= cmdWord(req_op, req_row, 5'd0, req_data[0]);
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (core_ack) begin
                        r_en    <= 1'b0;
                        r_col   <= r_col + 6'd1;
                        r_timer <= '0;
                        r_state <= S_ISSUE_GAP;
                    end else if (w_ackTimeout) begin
                        r_en       <= 1'b0;
                        r_err      <= 1'b1;
                        r_timer    <= '0;
`ifndef X1_ROWSEQ_VERIFY_EN
                        if (r_op) begin
                            r_rspData <= r_wdata;
                        end
`endif
                        r_rspValid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_ISSUE_GAP: begin
                    if (r_col == 6'd32) begin
                        if (r_readPhase) begin
                            r_en    <= 1'b1;
                            r_wrb   <= 1'b0;
                            r_di    <= 32'd0;
                            r_state <= S_POLL;
                        end else begin
`ifdef X1_ROWSEQ_VERIFY_EN
                            r_readPhase <= 1'b1;
                            r_col       <= 6'd0;
                            r_en        <= 1'b1;
                            r_wrb       <= 1'b1;
                            r_di        <= cmdWord(1'b0, r_row, 5'd0, 1'b0);
                            r_state     <= S_ISSUE;
`else
                            r_rspData  <= r_wdata;
                            r_rspValid <= 1'b1;
                            r_state    <= S_RESP;
`endif
                        end
                    end else begin
                        r_en    <= 1'b1;
                        r_wrb   <= 1'b1;
                        r_di    <= cmdWord(~r_readPhase, r_row, r_col[4:0], w_colBit);
                        r_state <= S_ISSUE;
                    end
                end
                S_POLL: begin
                    if (core_ack) begin
                        r_en    <= 1'b0;
                        r_timer <= '0;
                        if (w_emptyHit) begin
                            r_empty <= r_empty + EW'(1);
                            if (w_lastEmpty) begin
                                r_err      <= 1'b1;
                                r_rspValid <= 1'b1;
                                r_state    <= S_RESP;
                            end else begin
                                r_state <= S_POLL_GAP;
                            end
                        end else begin
                            r_rspData <= w_collectData;
                            r_bit     <= r_bit + 6'd1;
                            r_empty   <= '0;
                            if (w_badUpper) begin
                                r_err <= 1'b1;
                            end
                            if (r_bit == 6'd31) begin
`ifdef X1_ROWSEQ_VERIFY_EN
                                if (r_op && (w_collectData != r_wdata)) begin
                                    r_err <= 1'b1;
                                end
`endif
                                r_rspValid <= 1'b1;
                                r_state    <= S_RESP;
                            end else begin
                                r_state <= S_POLL_GAP;
                            end
                        end
                    end else if (w_ackTimeout) begin
                        r_en       <= 1'b0;
                        r_err      <= 1'b1;
                        r_timer    <= '0;
                        r_rspValid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_POLL_GAP: begin
                    r_en    <= 1'b1;
                    r_wrb   <= 1'b0;
                    r_di    <= 32'd0;
                    r_state <= S_POLL;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuromorphic_x1_row_seq.sv
// tb_neuromorphic_x1_row_seq
// Directed bench for the X1 row sequencer, using a behavioural core model.
// Expected command words and responses are queued when a request is driven.
// They are popped when the core model sees an acked command or when the
// sequencer presents a response.
// Honours X1_ROWSEQ_VERIFY_EN so that it tracks the read-back build.
module tb_neuromorphic_x1_row_seq;

    localparam int ACK_TO   = 16;
    localparam int POLL_LIM = 8;

    logic        CLKin = 1'b0;
    logic        RSTin = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [4:0]  req_row = 5'd0;
    logic [31:0] req_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        EN;
    logic        W_RB;
    logic [31:0] DI;
    logic [31:0] DO = 32'd0;
    logic        core_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [32:0] expCmd[$];
    logic [32:0] expRsp[$];
    logic [31:0] cmdLog[$];
    logic        readQ[$];
    logic [31:0] mem [32];

    logic   stuckAck = 1'b0;
    logic   alwaysEmpty = 1'b0;
    logic   flipCol3 = 1'b0;
    logic   garbageFirst = 1'b0;
    int     emptyMode = 0;
    int     emptyLeft = 0;
    int     rdIdx = 0;
    int     emptyCount = 0;
    int     ackCount = 0;
    int     waitCnt = 0;
    int     lat = 0;
    longint cyc = 0;
    longint lastAckCyc = 0;
    logic   gapPending = 1'b0;
    logic   modelAck = 1'b0;
    logic   spurAck = 1'b0;
    logic [4:0] mRow;
    logic [4:0] mCol;
    logic       mBit;

    assign core_ack = modelAck | spurAck;

    neuromorphic_x1_row_seq #(
        .ACK_TIMEOUT(ACK_TO),
        .POLL_LIMIT (POLL_LIM)
    ) dut (
        .CLKin    (CLKin),
        .RSTin    (RSTin),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_row  (req_row),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .EN       (EN),
        .W_RB     (W_RB),
        .DI       (DI),
        .DO       (DO),
        .core_ack (core_ack),
        .busy     (busy)
    );

    // Free-running clock, 10 time units per period
    initial begin
        forever #5 CLKin = ~CLKin;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] cmdWord(input logic prog, input int row,
                                            input int col, input logic b);
        logic [31:0] w;
        w        = 32'h0;
        w[31:30] = prog ? 2'b11 : 2'b01;
        w[29:25] = row[4:0];
        w[24:20] = col[4:0];
        w[7:0]   = (prog && b) ? 8'hFF : 8'h00;
        return w;
    endfunction

    // 50 empty polls in total, spread so that no run reaches the poll limit
    function automatic int planEmpties(input int k);
        if (emptyMode != 1) return 0;
        if (k < 7) return 7;
        if (k == 7) return 1;
        return 0;
    endfunction

    task automatic serveCommand();
        cmdLog.push_back(DI);
        ackCount++;
        lastAckCyc = cyc;
        gapPending = 1'b1;
        if (expCmd.size() == 0) checkOutput("cmdQueueSize", 64'(expCmd.size()), 64'd1);
        else checkOutput("cmd", {31'd0, W_RB, DI}, {31'd0, expCmd.pop_front()});
        if (W_RB) begin
            mRow = DI[29:25];
            mCol = DI[24:20];
            if (DI[31:30] == 2'b11) mem[mRow][mCol] = (DI[7:0] == 8'hFF) ^ (flipCol3 && mCol == 5'd3);
            else readQ.push_back(mem[mRow][mCol]);
            DO = 32'h0;
        end else if (alwaysEmpty || emptyLeft > 0) begin
            DO = 32'hDEAD_C0DE;
            if (emptyLeft > 0) emptyLeft--;
            emptyCount++;
        end else begin
            mBit = (readQ.size() > 0) ? readQ.pop_front() : 1'b0;
            DO = {31'd0, mBit};
            if (garbageFirst && rdIdx == 0) DO[8] = 1'b1;
            rdIdx++;
            emptyLeft = planEmpties(rdIdx);
        end
    endtask

    // Core model: acks each strobe after a random 0-2 cycle wait and checks the one-cycle EN gap
    always @(negedge CLKin) begin
        cyc++;
        modelAck = 1'b0;
        if (EN && gapPending) begin
            checkOutput("enGap", 64'(cyc - lastAckCyc), 64'd2);
            gapPending = 1'b0;
        end
        if (EN && !stuckAck && !RSTin) begin
            if (waitCnt >= lat) begin
                modelAck = 1'b1;
                waitCnt  = 0;
                lat      = $urandom_range(0, 2);
                serveCommand();
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    task automatic prepModel(input int mode);
        readQ.delete();
        cmdLog.delete();
        rdIdx      = 0;
        emptyMode  = mode;
        emptyLeft  = planEmpties(0);
        emptyCount = 0;
    endtask

    task automatic pushReadExpect(input int row, input int polls);
        for (int c = 0; c < 32; c++) expCmd.push_back({1'b1, cmdWord(1'b0, row, c, 1'b0)});
        for (int p = 0; p < polls; p++) expCmd.push_back(33'd0);
    endtask

    task automatic pushWriteExpect(input int row, input logic [31:0] data);
        for (int c = 0; c < 32; c++) expCmd.push_back({1'b1, cmdWord(1'b1, row, c, data[c])});
`ifdef X1_ROWSEQ_VERIFY_EN
        pushReadExpect(row, 32);
`endif
    endtask

    task automatic applyStimulus(input logic op, input logic [4:0] row, input logic [31:0] data);
        @(posedge CLKin); #1;
        req_op     = op;
        req_row    = row;
        req_data   = data;
        req_valid  = 1'b1;
        gapPending = 1'b0;
        @(posedge CLKin); #1;
        req_valid = 1'b0;
        checkOutput("accept", 64'(busy), 64'd1);
    endtask

    task automatic waitResponse(input string tag, input logic readyEarly);
        logic [32:0] exp;
        int n;
        n = 0;
        rsp_ready = readyEarly;
        while (!rsp_valid && n < 3000) begin
            @(posedge CLKin); #1;
            n++;
        end
        exp = (expRsp.size() > 0) ? expRsp.pop_front() : 33'd0;
        if (!rsp_valid) begin
            checkOutput({tag, "_rspTimeout"}, 64'(rsp_valid), 64'd1);
            rsp_ready = 1'b0;
            return;
        end
        checkOutput({tag, "_data"}, 64'(rsp_data), 64'(exp[31:0]));
        checkOutput({tag, "_err"}, 64'(rsp_err), 64'(exp[32]));
        if (!readyEarly) begin
            @(posedge CLKin); #1;
            checkOutput({tag, "_hold"}, {30'd0, rsp_valid, rsp_err, rsp_data}, {30'd0, 1'b1, exp});
            rsp_ready = 1'b1;
        end
        @(posedge CLKin); #1;
        rsp_ready = 1'b0;
        checkOutput({tag, "_done"}, {62'd0, rsp_valid, busy}, 64'd0);
    endtask

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        int n;
        logic sawValid;
        for (int r = 0; r < 32; r++) mem[r] = 32'd0;

        // Reset state
        #2 RSTin = 1'b1;
        repeat (3) @(posedge CLKin);
        #1;
        checkOutput("rstEN", {61'd0, EN, W_RB, busy}, 64'd0);
        checkOutput("rstDI", 64'(DI), 64'd0);
        checkOutput("rstRsp", {30'd0, rsp_valid, rsp_err, rsp_data}, 64'd0);
        checkOutput("rstReqReady", 64'(req_ready), 64'd0);
        @(negedge CLKin);
        RSTin = 1'b0;
        @(posedge CLKin); #1;
        checkOutput("readyAfterRst", 64'(req_ready), 64'd1);

        // Ack while EN is low is ignored
        spurAck = 1'b1;
        @(posedge CLKin); #1;
        spurAck = 1'b0;
        checkOutput("spuriousAck", {62'd0, busy, EN}, 64'd0);

        // Row write, row 5
        prepModel(0);
        pushWriteExpect(5, 32'hA5A50F0F);
        expRsp.push_back({1'b0, 32'hA5A50F0F});
        applyStimulus(1'b1, 5'd5, 32'hA5A50F0F);
        waitResponse("write", 1'b0);
        if (cmdLog.size() < 32) begin
            checkOutput("wrCmdCount", 64'(cmdLog.size()), 64'd32);
        end else begin
            checkOutput("wrDIfirst", 64'(cmdLog[0]), 64'hCA0000FF);
            checkOutput("wrDIcol4", 64'(cmdLog[4]), 64'hCA400000);
            checkOutput("wrDIlast", 64'(cmdLog[31]), 64'hCBF000FF);
        end
        checkOutput("wrDrained", 64'(expCmd.size()), 64'd0);

        // Row read with 50 interleaved empty polls
        prepModel(1);
        pushReadExpect(5, 82);
        expRsp.push_back({1'b0, 32'hA5A50F0F});
        applyStimulus(1'b0, 5'd5, 32'h0);
        waitResponse("read", 1'b0);
        if (cmdLog.size() > 0) checkOutput("rdDIfirst", 64'(cmdLog[0]), 64'h4A000000);
        else checkOutput("rdCmdCount", 64'(cmdLog.size()), 64'd114);
        checkOutput("rdEmpties", 64'(emptyCount), 64'd50);
        checkOutput("rdDrained", 64'(expCmd.size()), 64'd0);

        // Upper DO bits set on one result: sticky error, bit still taken from DO[0]
        prepModel(0);
        garbageFirst = 1'b1;
        pushReadExpect(5, 32);
        expRsp.push_back({1'b1, 32'hA5A50F0F});
        applyStimulus(1'b0, 5'd5, 32'h0);
        waitResponse("garbage", 1'b0);
        garbageFirst = 1'b0;
        checkOutput("gbDrained", 64'(expCmd.size()), 64'd0);

        // Poll limit of 8 with the core always empty; rsp_ready already high
        prepModel(0);
        alwaysEmpty = 1'b1;
        pushReadExpect(2, POLL_LIM);
        expRsp.push_back({1'b1, 32'h0});
        applyStimulus(1'b0, 5'd2, 32'h0);
        waitResponse("pollLimit", 1'b1);
        alwaysEmpty = 1'b0;
        checkOutput("plEmpties", 64'(emptyCount), 64'(POLL_LIM));
        checkOutput("plDrained", 64'(expCmd.size()), 64'd0);

        // Ack timeout of 16 cycles
        prepModel(0);
        stuckAck = 1'b1;
        applyStimulus(1'b1, 5'd1, 32'h12345678);
        n = 0;
        while (EN && n < 100) begin
            @(posedge CLKin); #1;
            n++;
        end
        checkOutput("toEnCycles", 64'(n), 64'(ACK_TO));
        checkOutput("toRsp", {62'd0, rsp_valid, rsp_err}, 64'd3);
        rsp_ready = 1'b1;
        @(posedge CLKin); #1;
        rsp_ready = 1'b0;
        stuckAck  = 1'b0;
        checkOutput("toIdle", 64'(busy), 64'd0);

        // Reset pulse while column 10 of a write is outstanding
        prepModel(0);
        pushWriteExpect(9, 32'hFFFF0000);
        n = ackCount;
        applyStimulus(1'b1, 5'd9, 32'hFFFF0000);
        for (int i = 0; i < 500 && (ackCount - n) < 10; i++) begin
            @(posedge CLKin); #1;
        end
        @(posedge CLKin); #1;
        checkOutput("rstMidCol", {62'd0, EN, W_RB, 27'd0, DI[24:20]}, {62'd0, 2'b11, 27'd0, 5'd10});
        RSTin = 1'b1;
        #1;
        checkOutput("rstMidEN", {61'd0, EN, busy, req_ready}, 64'd0);
        @(posedge CLKin); #1;
        RSTin = 1'b0;
        expCmd.delete();
        gapPending = 1'b0;
        @(posedge CLKin); #1;
        checkOutput("rstMidReady", 64'(req_ready), 64'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || EN) sawValid = 1'b1;
            @(posedge CLKin); #1;
        end
        checkOutput("rstMidNoRsp", 64'(sawValid), 64'd0);

`ifdef X1_ROWSEQ_VERIFY_EN
        // Read-back verify: core flips the stored bit at column 3
        prepModel(0);
        flipCol3 = 1'b1;
        pushWriteExpect(7, 32'h0);
        expRsp.push_back({1'b1, 32'h00000008});
        applyStimulus(1'b1, 5'd7, 32'h0);
        waitResponse("verify", 1'b0);
        flipCol3 = 1'b0;
        checkOutput("vfDrained", 64'(expCmd.size()), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
